// File: rtl/channel_accumulator_if.sv
// Beat/result bus between the tree-adder front end and the channel accumulator.
// The master side issues beats and consumes results; the slave side is the accumulator.
interface channel_accumulator_if #(
   parameter int unsigned WORD_WIDTH = 16,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH  = 8
) ();
   logic                         valid;
   logic                         last;
   logic signed [ACC_WIDTH-1:0]  bias;
   logic signed [WORD_WIDTH-1:0] sum;
   logic                         in_ready;
   logic                         out_valid;
   logic signed [OUT_WIDTH-1:0]  data;
   logic                         ready;
   logic                         overflow;

   modport master (
      output valid, last, bias, sum, ready,
      input  in_ready, out_valid, data, overflow
   );

   modport slave (
      input  valid, last, bias, sum, ready,
      output in_ready, out_valid, data, overflow
   );
endinterface

// File: rtl/channel_accumulator.sv
// Re-aligns beat valid/last/bias with the adder's delayed sum, accumulates channels per pixel,
// applies bias/ReLU/saturation and queues results in a credit-protected output FIFO.
module channel_accumulator #(
   parameter int unsigned WORD_WIDTH    = 16,
   parameter int unsigned ACC_WIDTH     = 32,
   parameter int unsigned OUT_WIDTH     = 8,
   parameter int unsigned ADDER_LATENCY = 4,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter bit          RELU          = 1'b1
) (
   input logic                  clk,
   input logic                  rst_n,
   channel_accumulator_if.slave bus
);
   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + ADDER_LATENCY + 2) + 1;
   localparam int unsigned LastStage = ADDER_LATENCY - 1;
   localparam logic signed [ACC_WIDTH-1:0] SatMax =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SatMin =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic [ADDER_LATENCY-1:0]    dl_valid_q, dl_last_q;
   logic signed [ACC_WIDTH-1:0] dl_bias_q [ADDER_LATENCY];
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic                        first_q, fin_q;
   logic signed [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]             wr_q, rd_q;
   logic [CntW-1:0]             count_q, inflight;
   logic                        overflow_q;
   logic signed [ACC_WIDTH-1:0] relu_v;
   logic signed [OUT_WIDTH-1:0] result;
   logic                        beat_valid, push, pop, full;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl_valid_q <= '0;
         dl_last_q  <= '0;
         for (int i = 0; i < ADDER_LATENCY; i++) dl_bias_q[i] <= '0;
      end else begin
         dl_valid_q[0] <= bus.valid;
         dl_last_q[0]  <= bus.last;
         dl_bias_q[0]  <= bus.bias;
         for (int i = 1; i < ADDER_LATENCY; i++) begin
            dl_valid_q[i] <= dl_valid_q[i-1];
            dl_last_q[i]  <= dl_last_q[i-1];
            dl_bias_q[i]  <= dl_bias_q[i-1];
         end
      end
   end

   assign beat_valid = dl_valid_q[LastStage];

   // Accumulator wraps freely; saturation only happens once the pixel is complete.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         first_q <= 1'b1;
         fin_q   <= 1'b0;
      end else begin
         fin_q <= beat_valid & dl_last_q[LastStage];
         if (beat_valid) begin
            acc_q   <= (first_q ? dl_bias_q[LastStage] : acc_q) + ACC_WIDTH'(bus.sum);
            first_q <= dl_last_q[LastStage];
         end
      end
   end

   always_comb begin
      relu_v = acc_q;
      if (RELU && (acc_q < 0)) relu_v = '0;
      if (relu_v > SatMax)      result = SatMax[OUT_WIDTH-1:0];
      else if (relu_v < SatMin) result = SatMin[OUT_WIDTH-1:0];
      else                      result = relu_v[OUT_WIDTH-1:0];
   end

   assign push = fin_q;
   assign pop  = (count_q != '0) & bus.ready;
   assign full = (count_q == CntW'(FIFO_DEPTH));

   // A pop in the same cycle frees the head slot, so push is legal even when full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push && (!full || pop)) begin
            mem_q[wr_q] <= result;
            wr_q        <= ptr_inc(wr_q);
         end
         if (pop) rd_q <= ptr_inc(rd_q);
         if (push && full && !pop) overflow_q <= 1'b1;
         if ((push && !full) && !pop)     count_q <= count_q + CntW'(1);
         else if (pop && !push)           count_q <= count_q - CntW'(1);
      end
   end

   always_comb begin
      inflight = CntW'(fin_q);
      for (int i = 0; i < ADDER_LATENCY; i++) begin
         inflight = inflight + CntW'(dl_valid_q[i] & dl_last_q[i]);
      end
   end

   assign bus.in_ready  = (count_q + inflight) < CntW'(FIFO_DEPTH);
   assign bus.out_valid = (count_q != '0);
   assign bus.data      = mem_q[rd_q];
   assign bus.overflow  = overflow_q;
endmodule
